ct_tag_serializer: RTL and testbench

CT_TAG_SERIALIZER -- requirements
Module: ct_tag_serializer

---
 rtl/ascon_pkg.sv | 17 +
 rtl/ct_tag_serializer_if.sv | 26 ++
 rtl/byte_shift_reg.sv | 39 +++
 rtl/ct_tag_serializer.sv | 125 ++++++++++++
 tb/tb_ct_tag_serializer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// Shared constants and FSM state encoding for the ct/tag byte serializer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: CT_BYTES / TAG_BYTES / FRAME_BYTES defaults and the state_e encoding.
package ascon_pkg;

  localparam int CT_BYTES    = 5;
  localparam int TAG_BYTES   = 16;
  localparam int FRAME_BYTES = CT_BYTES + TAG_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CT   = 2'd1,
    TAG  = 2'd2
  } state_e;

endpackage

// File: rtl/ct_tag_serializer_if.sv
// Byte stream handshake bundle between the serializer and its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer drives out_ready; a byte moves only when out_valid & out_ready.
// Signals: out_data[7:0], out_valid, out_last (source -> sink), out_ready (sink -> source).
interface ct_tag_serializer_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/byte_shift_reg.sv
// Parallel-load frame register that shifts one byte towards the MSB end per enable.
// Latency: load/shift visible on msb_o the cycle after the enable.
// Backpressure: none; holds its contents whenever neither load_i nor shift_i is set.
// Ports: clk, rst (sync, active-high), load_i, shift_i, din_i[8*NBYTES-1:0], msb_o[7:0].
module byte_shift_reg #(
  parameter int NBYTES = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [8*NBYTES-1:0]   din_i,
  output logic [7:0]            msb_o
);

  logic [8*NBYTES-1:0] data_q;
  logic [8*NBYTES-1:0] data_d;

  // Load wins over shift; the serializer never asks for both at once.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = din_i;
    end else if (shift_i) begin
      data_d = {data_q[8*NBYTES-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[8*NBYTES-1 -: 8];

endmodule

// File: rtl/ct_tag_serializer.sv
// Captures {ct, tag} on a rising encryption_fin and streams it MSB byte first.
// Latency: first byte valid 1 cycle after the start edge is sampled; one byte per accepted transfer.
// Backpressure: out_ready low stalls the stream with data/valid/last held; a start while busy is dropped and sets overrun.
// Ports: clk, rst, encryption_fin, ct, tag in; out_if (master stream); busy, done, overrun status out.
module ct_tag_serializer #(
  parameter int CT_BYTES  = ascon_pkg::CT_BYTES,
  parameter int TAG_BYTES = ascon_pkg::TAG_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    encryption_fin,
  input  logic [8*CT_BYTES-1:0]   ct,
  input  logic [8*TAG_BYTES-1:0]  tag,
  ct_tag_serializer_if.master     out_if,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  import ascon_pkg::*;

  localparam int            NBYTES   = CT_BYTES + TAG_BYTES;
  localparam int            CW       = $clog2(NBYTES);
  localparam logic [CW-1:0] CT_LAST  = CW'(CT_BYTES - 1);
  localparam logic [CW-1:0] FRM_LAST = CW'(NBYTES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin_q;
  logic          done_q;
  logic          overrun_q, overrun_d;
  logic          start;
  logic          xfer;
  logic          at_last;
  logic          load;
  logic          shift;
  logic          valid;
  logic [7:0]    msb;

  assign start   = encryption_fin & ~fin_q;
  assign valid   = (state_q != IDLE);
  assign at_last = (cnt_q == FRM_LAST);
  assign xfer    = valid & out_if.out_ready;

  // Outputs are pure functions of registered state, so they cannot move during a stall.
  assign out_if.out_valid = valid;
  assign out_if.out_last  = valid & at_last;
  assign out_if.out_data  = valid ? msb : 8'h00;
  assign busy             = valid;
  assign done             = done_q;
  assign overrun          = overrun_q;

  byte_shift_reg #(
    .NBYTES (NBYTES)
  ) u_frame (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   ({ct, tag}),
    .msb_o   (msb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CT;
        end
      end
      CT: begin
        if (xfer) begin
          shift = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CT_LAST) begin
            state_d = TAG;
          end
        end
      end
      TAG: begin
        if (xfer) begin
          shift = 1'b1;
          if (at_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Any start edge outside IDLE (including the final-transfer cycle) is a lost frame.
    if (start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fin_q     <= encryption_fin;
      done_q    <= xfer & at_last;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ct_tag_serializer.sv
// Self-checking bench for ct_tag_serializer: directed scenarios plus randomized frames and ready patterns.
// Latency: n/a.
// Backpressure: out_ready driven always-high, alternating or random.
module tb_ct_tag_serializer;

  localparam int CTB = 5;
  localparam int TGB = 16;
  localparam int FB  = CTB + TGB;

  logic              clk = 1'b0;
  logic              rst;
  logic              encryption_fin;
  logic [8*CTB-1:0]  ct;
  logic [8*TGB-1:0]  tag;
  logic              busy, done, overrun;

  ct_tag_serializer_if sif();

  ct_tag_serializer #(
    .CT_BYTES  (CTB),
    .TAG_BYTES (TGB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .encryption_fin (encryption_fin),
    .ct             (ct),
    .tag            (tag),
    .out_if         (sif),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [8:0] got_q[$];
  int         xfer_cyc[$];
  int         done_cyc[$];
  int         rdy_mode = 0;
  int         alt_base = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_obs = '0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: byte k of a frame is simply the k-th byte counted from the MSB end of {ct, tag}.
  function automatic logic [7:0] exp_byte(input logic [8*FB-1:0] frm, input int k);
    logic [8*FB-1:0] t;
    t = frm >> (8 * (FB - 1 - k));
    return t[7:0];
  endfunction

  // Monitor: records accepted bytes, done pulses, and checks stall hold / idle zero.
  always @(negedge clk) begin
    cyc++;
    if (prev_stall)
      check_eq("stall_hold", {sif.out_valid, sif.out_last, sif.out_data}, prev_obs);
    if (!sif.out_valid)
      check_eq("idle_data_zero", sif.out_data, 8'h00);
    if (sif.out_valid && sif.out_ready && !rst) begin
      got_q.push_back({sif.out_last, sif.out_data});
      xfer_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    prev_stall = sif.out_valid && !sif.out_ready && !rst;
    prev_obs   = {sif.out_valid, sif.out_last, sif.out_data};
  end

  // Ready driver: 0 = always ready, 1 = low on the first valid cycle then alternating, else random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = ((cyc + 1 - alt_base) % 2) != 0;
      default: sif.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [8*FB-1:0] frm, output int c);
    @(posedge clk);
    alt_base = cyc + 2;
    #1;
    {ct, tag} = frm;
    encryption_fin = 1'b1;
    c = cyc;
  endtask

  task automatic wait_xfers(input string name, input int target, input int limit);
    int n;
    n = 0;
    while (got_q.size() < target && n < limit) begin
      tick(1);
      n++;
    end
    if (got_q.size() < target) check_eq({name, "_timeout"}, got_q.size(), target);
  endtask

  task automatic check_frame(input string name, input logic [8*FB-1:0] frm, input int base);
    check_eq({name, "_len"}, got_q.size() - base, FB);
    for (int k = 0; k < FB && base + k < got_q.size(); k++) begin
      check_eq({name, "_byte"}, got_q[base+k][7:0], exp_byte(frm, k));
      check_eq({name, "_last"}, got_q[base+k][8], (k == FB - 1));
    end
  endtask

  function automatic int xc(input int i);
    return (i < xfer_cyc.size()) ? xfer_cyc[i] : -1;
  endfunction

  function automatic int dc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int              c, base, nd;
    logic [8*FB-1:0] f0, fr;
    logic [191:0]    rnd;

    rst = 1'b1;
    encryption_fin = 1'b0;
    ct = '0;
    tag = '0;
    f0 = {40'h0123456789, 128'h00112233445566778899aabbccddeeff};
    tick(3);

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", sif.out_valid, 1'b0);
    check_eq("rst_last", sif.out_last, 1'b0);
    check_eq("rst_data", sif.out_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Back-to-back accept
    rdy_mode = 0;
    base = got_q.size(); nd = done_cyc.size();
    fire(f0, c);
    tick(3);
    encryption_fin = 1'b0;
    wait_xfers("b2b", base + FB, 100);
    tick(2);
    check_frame("b2b", f0, base);
    check_eq("b2b_first_cyc", xc(base), c + 2);
    check_eq("b2b_last_cyc", xc(base + FB - 1), c + FB + 1);
    check_eq("b2b_done_cnt", done_cyc.size() - nd, 1);
    check_eq("b2b_done_cyc", dc(nd), c + FB + 2);
    check_eq("b2b_busy_after", busy, 1'b0);

    // Backpressure: ready low on every other cycle starting with the first valid one
    rdy_mode = 1;
    base = got_q.size(); nd = done_cyc.size();
    fire(f0, c);
    tick(3);
    encryption_fin = 1'b0;
    wait_xfers("bp", base + FB, 200);
    tick(2);
    rdy_mode = 0;
    check_frame("bp", f0, base);
    check_eq("bp_first_cyc", xc(base), c + 3);
    check_eq("bp_span", xc(base + FB - 1) - (c + 2), 41);
    check_eq("bp_done_cyc", dc(nd), c + 44);

    // Overrun: second edge while byte index 7 is presented
    base = got_q.size(); nd = done_cyc.size();
    fire(f0, c);
    tick(2);
    encryption_fin = 1'b0;
    wait_xfers("ovr_pre", base + 7, 50);
    check_eq("ovr_before", overrun, 1'b0);
    encryption_fin = 1'b1;
    wait_xfers("ovr", base + FB, 100);
    tick(30);
    check_frame("ovr", f0, base);
    check_eq("ovr_flag", overrun, 1'b1);
    check_eq("ovr_done_cnt", done_cyc.size() - nd, 1);
    check_eq("ovr_busy_after", busy, 1'b0);
    encryption_fin = 1'b0;
    tick(2);

    // Reset mid-frame after 10 transfers
    base = got_q.size();
    fire(f0, c);
    tick(2);
    encryption_fin = 1'b0;
    wait_xfers("rstmid", base + 10, 50);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_valid", sif.out_valid, 1'b0);
    check_eq("rstmid_busy", busy, 1'b0);
    check_eq("rstmid_overrun", overrun, 1'b0);
    check_eq("rstmid_len", got_q.size() - base, 10);
    for (int k = 0; k < 10 && base + k < got_q.size(); k++)
      check_eq("rstmid_byte", got_q[base+k][7:0], exp_byte(f0, k));
    tick(1);
    base = got_q.size();
    fire(f0, c);
    tick(2);
    encryption_fin = 1'b0;
    wait_xfers("restart", base + FB, 100);
    tick(2);
    check_frame("restart", f0, base);
    check_eq("restart_first_cyc", xc(base), c + 2);

    // fin held high for 100 cycles, then a reset with fin still high restarts immediately
    base = got_q.size(); nd = done_cyc.size();
    fire(f0, c);
    tick(100);
    check_eq("hold_len", got_q.size() - base, FB);
    check_eq("hold_done_cnt", done_cyc.size() - nd, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    c = cyc;
    wait_xfers("relfin", base + 2 * FB, 100);
    tick(2);
    check_frame("relfin", f0, base + FB);
    check_eq("relfin_first_cyc", xc(base + FB), c + 2);
    encryption_fin = 1'b0;
    tick(2);

    // Randomized frames with random ready
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      fr = rnd[8*FB-1:0];
      base = got_q.size(); nd = done_cyc.size();
      fire(fr, c);
      tick($urandom_range(1, 4));
      encryption_fin = 1'b0;
      wait_xfers("rnd", base + FB, 400);
      tick(2);
      check_frame("rnd", fr, base);
      check_eq("rnd_done_cnt", done_cyc.size() - nd, 1);
      check_eq("rnd_overrun", overrun, 1'b0);
      tick($urandom_range(0, 3));
    end
    rdy_mode = 0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
